aes_inv_round_ctrl: RTL and testbench

Sequencer for the AES-128 decryption datapath. Takes one 128-bit ciphertext and drives the four inverse-round step modules (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) in FIPS-197 inverse-cipher order, using each module's En/Ry handshake. It requests round keys by index and delivers the plaintext with a Done pulse. It sits between the top-level AES core interface and the step modules.

---
 rtl/aes_inv_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 inverse-cipher sequencer: walks the 40 inverse-round steps over the
// step modules with an En/Ry handshake, one GAP cycle between steps.
module aes_inv_round_ctrl #(
    parameter int unsigned RY_TIMEOUT = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] Cipher_Text,
    output logic [3:0]   Key_Idx,
    input  logic [127:0] Round_Key,
    output logic [127:0] Step_Text,
    output logic [127:0] Step_Key,
    output logic         Shift_En,
    output logic         Sub_En,
    output logic         Add_En,
    output logic         Mix_En,
    input  logic         Shift_Ry,
    input  logic         Sub_Ry,
    input  logic         Add_Ry,
    input  logic         Mix_Ry,
    input  logic [127:0] Shift_Out,
    input  logic [127:0] Sub_Out,
    input  logic [127:0] Add_Out,
    input  logic [127:0] Mix_Out,
    output logic [127:0] Plain_Text,
    output logic         Busy,
    output logic         Done,
    output logic         Error
);

    localparam int unsigned TW = $clog2(RY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHIFT, S_SUB, S_MIX, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t         r_state;
    state_t         w_next;
    state_t         r_after_gap;
    state_t         w_after_cap;
    logic [127:0]   r_state_reg;
    logic [127:0]   r_plain;
    logic [127:0]   w_step_out;
    logic [3:0]     r_round_ctr;
    logic [TW-1:0]  r_tmo;
    logic           r_done;
    logic           w_start_acc;
    logic           w_in_step;
    logic           w_ry;
    logic           w_capture;
    logic           w_timeout;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_after_cap = S_GAP;
        w_step_out  = r_state_reg;
        w_start_acc = 1'b0;
        w_in_step   = 1'b0;
        w_ry        = 1'b0;
        Shift_En    = 1'b0;
        Sub_En      = 1'b0;
        Add_En      = 1'b0;
        Mix_En      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_next      = S_ADD;
                end
            end
            S_ADD: begin
                Add_En     = 1'b1;
                w_in_step  = 1'b1;
                w_ry       = Add_Ry;
                w_step_out = Add_Out;
                // First ADD is followed by SHIFT, the key-0 ADD ends the run, all others by MIX
                if (r_round_ctr == 4'd0) begin
                    w_after_cap = S_DONE;
                end else if (r_round_ctr == 4'd10) begin
                    w_after_cap = S_SHIFT;
                end else begin
                    w_after_cap = S_MIX;
                end
            end
            S_SHIFT: begin
                Shift_En    = 1'b1;
                w_in_step   = 1'b1;
                w_ry        = Shift_Ry;
                w_step_out  = Shift_Out;
                w_after_cap = S_SUB;
            end
            S_SUB: begin
                Sub_En      = 1'b1;
                w_in_step   = 1'b1;
                w_ry        = Sub_Ry;
                w_step_out  = Sub_Out;
                w_after_cap = S_ADD;
            end
            S_MIX: begin
                Mix_En      = 1'b1;
                w_in_step   = 1'b1;
                w_ry        = Mix_Ry;
                w_step_out  = Mix_Out;
                w_after_cap = S_SHIFT;
            end
            S_GAP: begin
                w_next = r_after_gap;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_capture = w_in_step && w_ry;
        w_timeout = w_in_step && !w_ry && (r_tmo == TW'(RY_TIMEOUT - 1));
        if (w_capture) begin
            w_next = S_GAP;
        end else if (w_timeout) begin
            w_next = S_ERR;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state_reg <= '0;
            r_plain     <= '0;
            r_round_ctr <= 4'd10;
            r_tmo       <= '0;
            r_done      <= 1'b0;
            r_after_gap <= S_IDLE;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_state_reg <= Cipher_Text;
                r_round_ctr <= 4'd10;
            end
            if (w_capture) begin
                r_state_reg <= w_step_out;
                r_after_gap <= w_after_cap;
                if (r_state == S_ADD && r_round_ctr != 4'd0) begin
                    r_round_ctr <= r_round_ctr - 4'd1;
                end
            end
            if (w_in_step && !w_capture && !w_timeout) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end
            if (r_state == S_GAP && r_after_gap == S_DONE) begin
                r_plain <= r_state_reg;
                r_done  <= 1'b1;
            end
        end
    end

    assign Key_Idx    = r_round_ctr;
    assign Step_Text  = r_state_reg;
    assign Step_Key   = Round_Key;
    assign Plain_Text = r_plain;
    assign Busy       = w_in_step || (r_state == S_GAP);
    assign Done       = r_done;
    assign Error      = (r_state == S_ERR);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: behavioural AES step modules with tunable Ry
// latency, known-answer table, corner sequences and encrypt-then-decrypt randoms.
module tb_aes_inv_round_ctrl;

    localparam int unsigned RY_TIMEOUT = 16;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [127:0] Cipher_Text;
    logic [3:0]   Key_Idx;
    logic [127:0] Round_Key;
    logic [127:0] Step_Text;
    logic [127:0] Step_Key;
    logic         Shift_En, Sub_En, Add_En, Mix_En;
    logic         Shift_Ry, Sub_Ry, Add_Ry, Mix_Ry;
    logic [127:0] Shift_Out, Sub_Out, Add_Out, Mix_Out;
    logic [127:0] Plain_Text;
    logic         Busy, Done, Error;

    aes_inv_round_ctrl #(.RY_TIMEOUT(RY_TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Cipher_Text(Cipher_Text),
        .Key_Idx(Key_Idx), .Round_Key(Round_Key), .Step_Text(Step_Text),
        .Step_Key(Step_Key), .Shift_En(Shift_En), .Sub_En(Sub_En),
        .Add_En(Add_En), .Mix_En(Mix_En), .Shift_Ry(Shift_Ry), .Sub_Ry(Sub_Ry),
        .Add_Ry(Add_Ry), .Mix_Ry(Mix_Ry), .Shift_Out(Shift_Out),
        .Sub_Out(Sub_Out), .Add_Out(Add_Out), .Mix_Out(Mix_Out),
        .Plain_Text(Plain_Text), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];

    assign Round_Key = rk[Key_Idx];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = v[127-8*i -: 8];
            o[127-8*i -: 8] = inv ? isbox[b] : sbox[b];
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   k [4];
        k[0] = inv ? 8'h0e : 8'h02;
        k[1] = inv ? 8'h0b : 8'h03;
        k[2] = inv ? 8'h0d : 8'h01;
        k[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = v[127-8*(j+4*c) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = gmul(a[r], k[0]) ^ gmul(a[(r+1)%4], k[1])
                                      ^ gmul(a[(r+2)%4], k[2]) ^ gmul(a[(r+3)%4], k[3]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < 10) s = mix_columns(s, 1'b0);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    // Step module models: index 0 shift, 1 sub, 2 add, 3 mix
    logic [3:0]   w_en;
    int           lat   [4];
    bit           stuck [4];
    bit           noise_on;
    int           m_cnt [4];
    logic [3:0]   m_ry;
    logic [127:0] m_out [4];
    logic [3:0]   m_nz;

    assign w_en = {Mix_En, Add_En, Sub_En, Shift_En};

    function automatic logic [127:0] step_fn(input int m, input logic [127:0] t, input logic [127:0] k);
        case (m)
            0:       return shift_rows(t, 1'b1);
            1:       return sub_bytes(t, 1'b1);
            2:       return t ^ k;
            default: return mix_columns(t, 1'b1);
        endcase
    endfunction

    always @(posedge Clk) begin
        for (int m = 0; m < 4; m++) begin
            if (!w_en[m]) begin
                m_cnt[m] <= 0;
                m_ry[m]  <= 1'b0;
            end else begin
                m_cnt[m] <= m_cnt[m] + 1;
                m_ry[m]  <= !stuck[m] && (m_cnt[m] + 1 >= lat[m]);
                m_out[m] <= step_fn(m, Step_Text, Step_Key);
            end
        end
        m_nz <= 4'($urandom);
    end

    // Noise only appears on a module's Ry while another module is enabled
    assign Shift_Ry = m_ry[0] | (noise_on & (|(w_en & 4'b1110)) & m_nz[0]);
    assign Sub_Ry   = m_ry[1] | (noise_on & (|(w_en & 4'b1101)) & m_nz[1]);
    assign Add_Ry   = m_ry[2] | (noise_on & (|(w_en & 4'b1011)) & m_nz[2]);
    assign Mix_Ry   = m_ry[3] | (noise_on & (|(w_en & 4'b0111)) & m_nz[3]);
    assign Shift_Out = m_out[0];
    assign Sub_Out   = m_out[1];
    assign Add_Out   = m_out[2];
    assign Mix_Out   = m_out[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ctrl"}, 128'({w_en, Busy, Done, Error}), 128'd0);
        check({tag, " key_idx"}, 128'(Key_Idx), 128'd10);
        check({tag, " plain"}, Plain_Text, 128'd0);
        check({tag, " step_text"}, Step_Text, 128'd0);
    endtask

    task automatic start_op(input logic [127:0] ct);
        @(negedge Clk);
        Start       = 1'b1;
        Cipher_Text = ct;
        @(posedge Clk);
    endtask

    // Call right after the edge that accepted Start; cycle k is sampled at the k-th negedge
    task automatic monitor_run(input string tag, input logic [127:0] exp_pt, input int exp_done,
                               input int exp_err, input int pa, input int pb,
                               input bit hold, input logic [127:0] hold_ct);
        int done_k   = -1;
        int err_k    = -1;
        int viol     = 0;
        int gaps     = 0;
        bit prev_gap = 1'b0;
        bit prev_add = 1'b0;
        bit key_ok;
        int keys [$];
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk);
            if ($countones(w_en) > 1) viol++;
            if (!(Done || Error) && Busy !== 1'b1) viol++;
            if ((Done || Error) && Busy !== 1'b0) viol++;
            if (Error && exp_err < 0) viol++;
            if (Busy && w_en == 4'b0) begin
                gaps++;
                if (prev_gap) viol++;
                prev_gap = 1'b1;
            end else begin
                prev_gap = 1'b0;
            end
            if (Add_En && !prev_add) keys.push_back(int'(Key_Idx));
            prev_add = Add_En;
            if (hold && k == 0) Cipher_Text = hold_ct;
            if (k == pa || k == pb) begin
                Start       = 1'b1;
                Cipher_Text = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                Start = hold;
            end
            if (Done) begin
                done_k = k;
                break;
            end
            if (Error) begin
                err_k = k;
                break;
            end
        end
        check({tag, " done_cycle"}, 128'(done_k), 128'(exp_done));
        check({tag, " error_cycle"}, 128'(err_k), 128'(exp_err));
        check({tag, " protocol_violations"}, 128'(viol), 128'd0);
        if (exp_done >= 0) begin
            check({tag, " plaintext"}, Plain_Text, exp_pt);
            check({tag, " gap_cycles"}, 128'(gaps), 128'd40);
            key_ok = (keys.size() == 11);
            foreach (keys[j]) if (keys[j] != 10 - j) key_ok = 1'b0;
            check({tag, " key_idx_sequence"}, 128'(key_ok), 128'd1);
        end else begin
            check({tag, " busy_done_error"}, 128'({Busy, Done, Error}), 128'b001);
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           l_shift;
        int           l_sub;
        int           l_add;
        int           l_mix;
        int           exp_done;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [4];
        logic [127:0] pt;
        logic [127:0] ct;
        int           v;
        int           e;

        tbl[0] = '{C1_KEY, C1_CT, C1_PT, 1, 1, 1, 1, 120};
        tbl[1] = '{C1_KEY, C1_CT, C1_PT, 1, 1, 1, 3, 138};
        tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                   128'h3243f6a8885a308d313198a2e0370734, 1, 1, 2, 1, 131};
        tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                   128'h3243f6a8885a308d313198a2e0370734, 2, 3, 1, 1, 150};

        Rst = 1'b0; Start = 1'b0; Cipher_Text = '0; noise_on = 1'b0;
        for (int m = 0; m < 4; m++) begin lat[m] = 1; stuck[m] = 1'b0; end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        init_sbox();
        repeat (3) @(negedge Clk);
        check_reset_state("reset");
        Rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            set_key(tbl[i].key);
            lat[0] = tbl[i].l_shift; lat[1] = tbl[i].l_sub;
            lat[2] = tbl[i].l_add;   lat[3] = tbl[i].l_mix;
            start_op(tbl[i].ct);
            monitor_run($sformatf("vec%0d", i), tbl[i].pt, tbl[i].exp_done, -1, -1, -1, 1'b0, '0);
            @(negedge Clk);
            check($sformatf("vec%0d done_single_pulse", i), 128'({Done, Busy}), 128'd0);
            check($sformatf("vec%0d plain_held", i), Plain_Text, tbl[i].pt);
        end
        for (int m = 0; m < 4; m++) lat[m] = 1;

        // Add step never ready: timeout, then recovery on the next Start
        set_key(C1_KEY);
        stuck[2] = 1'b1;
        start_op(C1_CT);
        monitor_run("timeout", '0, -1, 16, -1, -1, 1'b0, '0);
        v = 0;
        repeat (4) begin
            @(negedge Clk);
            if (w_en != 4'b0 || Done || !Error) v++;
        end
        check("timeout error_held", 128'(v), 128'd0);
        stuck[2] = 1'b0;
        start_op(C1_CT);
        monitor_run("after_timeout", C1_PT, 120, -1, -1, -1, 1'b0, '0);

        start_op(C1_CT);
        monitor_run("start_ignored", C1_PT, 120, -1, 5, 60, 1'b0, '0);

        // Reset mid-run
        start_op(C1_CT);
        Start = 1'b0;
        for (int k = 0; k <= 50; k++) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_state("mid_reset");
        @(negedge Clk);
        check("mid_reset no_enable", 128'({w_en, Busy}), 128'd0);
        Rst = 1'b1;
        start_op(C1_CT);
        monitor_run("after_reset", C1_PT, 120, -1, -1, -1, 1'b0, '0);

        // Start held through Done: second run accepted in the DONE cycle
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt);
        start_op(C1_CT);
        monitor_run("b2b_first", C1_PT, 120, -1, -1, -1, 1'b1, ct);
        @(posedge Clk);
        monitor_run("b2b_second", pt, 120, -1, -1, -1, 1'b0, '0);

        // Random keys/plaintexts, random latencies, Ry noise on idle modules
        noise_on = 1'b1;
        for (int r = 0; r < 6; r++) begin
            set_key({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt);
            for (int m = 0; m < 4; m++) lat[m] = int'($urandom_range(3, 1));
            e = 10 * (lat[0] + 2) + 10 * (lat[1] + 2) + 11 * (lat[2] + 2) + 9 * (lat[3] + 2);
            start_op(ct);
            monitor_run($sformatf("rand%0d", r), pt, e, -1, -1, -1, 1'b0, '0);
        end
        noise_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
